// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm -- multi-cycle MIPS control unit.
//
// Sequences a shared datapath (PC, unified instruction/data memory port,
// register file, sign/zero extender, ALU) through fetch, decode, execute,
// memory and writeback states. Memory accesses wait on mem_ready_i.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous reset, active-low
//   op_i             opcode, instr[31:26] from the IR
//   zero_i           ALU zero flag (consumed by datapath PC-load gating)
//   mem_ready_i      memory completes the current access this cycle
//   pc_write_o       unconditional PC load
//   pc_write_cond_o  PC load if zero (beq)
//   i_or_d_o         memory address select: 0=PC, 1=ALUOut
//   mem_read_o       memory read request
//   mem_write_o      memory write request
//   ir_write_o       IR load
//   mem_to_reg_o     writeback source: 1=MDR, 0=ALUOut
//   reg_dst_o        destination register: 1=rd, 0=rt
//   reg_write_o      register file write
//   alu_src_a_o      ALU A: 0=PC, 1=rs
//   alu_src_b_o      ALU B: 0=rt, 1=4, 2=ext imm, 3=ext imm<<2
//   alu_op_o         0=add, 1=sub, 2=funct, 3=slt
//   pc_src_o         0=ALU, 1=ALUOut, 2=jump target
//   ext_zero_o       1=zero-extend immediate, 0=sign-extend
//   illegal_o        sticky: unknown opcode decoded
//   state_o          current state (debug)
//
// Optional feature (macro MC_CTRL_PERF_CNT_EN):
//   cycle_cnt_o      cycles spent outside IDLE/HALT
//   instr_cnt_o      instructions retired (re-entries into FETCH)
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [OP_W-1:0] op_i,
  input  logic            zero_i,
  input  logic            mem_ready_i,
  output logic            pc_write_o,
  output logic            pc_write_cond_o,
  output logic            i_or_d_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            ir_write_o,
  output logic            mem_to_reg_o,
  output logic            reg_dst_o,
  output logic            reg_write_o,
  output logic            alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic [1:0]      alu_op_o,
  output logic [1:0]      pc_src_o,
  output logic            ext_zero_o,
  output logic            illegal_o,
  output logic [ST_W-1:0] state_o
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]     cycle_cnt_o,
  output logic [31:0]     instr_cnt_o
`endif
);

  localparam logic [ST_W-1:0] S_IDLE   = 'd0;
  localparam logic [ST_W-1:0] S_FETCH  = 'd1;
  localparam logic [ST_W-1:0] S_DECODE = 'd2;
  localparam logic [ST_W-1:0] S_MEMADR = 'd3;
  localparam logic [ST_W-1:0] S_MEMRD  = 'd4;
  localparam logic [ST_W-1:0] S_MEMWB  = 'd5;
  localparam logic [ST_W-1:0] S_MEMWR  = 'd6;
  localparam logic [ST_W-1:0] S_EXEC   = 'd7;
  localparam logic [ST_W-1:0] S_RWB    = 'd8;
  localparam logic [ST_W-1:0] S_BRANCH = 'd9;
  localparam logic [ST_W-1:0] S_JUMP   = 'd10;
  localparam logic [ST_W-1:0] S_IEXEC  = 'd11;
  localparam logic [ST_W-1:0] S_IWB    = 'd12;
  localparam logic [ST_W-1:0] S_HALT   = 'd13;

  localparam logic [OP_W-1:0] OP_RTYPE = 'h00;
  localparam logic [OP_W-1:0] OP_J     = 'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 'h0A;
  localparam logic [OP_W-1:0] OP_ORI   = 'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 'h23;
  localparam logic [OP_W-1:0] OP_SW    = 'h2B;

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_next;
  logic            r_illegal;
  logic [1:0]      w_imm_alu_op;
  logic            w_imm_ext_zero;

  // The zero flag only gates the PC load inside the datapath; the FSM itself
  // never branches on it.
  logic w_unused_zero;
  assign w_unused_zero = zero_i;

  // ALU operation and extension mode for immediate instructions. The IR is
  // stable outside FETCH, so these are decoded straight from op_i in both
  // IEXEC and IWB.
  always_comb begin
    w_imm_alu_op   = 2'd0;
    w_imm_ext_zero = 1'b0;
    if (op_i == OP_SLTI) begin
      w_imm_alu_op = 2'd3;
    end else if (op_i == OP_ORI) begin
      w_imm_alu_op   = 2'd2;
      w_imm_ext_zero = 1'b1;
    end
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  if (mem_ready_i) w_next = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_RTYPE:               w_next = S_EXEC;
          OP_LW, OP_SW:           w_next = S_MEMADR;
          OP_BEQ:                 w_next = S_BRANCH;
          OP_J:                   w_next = S_JUMP;
          OP_ADDI, OP_SLTI, OP_ORI: w_next = S_IEXEC;
          default:                w_next = S_HALT;
        endcase
      end
      S_MEMADR: w_next = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready_i) w_next = S_MEMWB;
      S_MEMWR:  if (mem_ready_i) w_next = S_FETCH;
      S_EXEC:   w_next = S_RWB;
      S_IEXEC:  w_next = S_IWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  // State and sticky illegal-opcode flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && w_next == S_HALT) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Moore output decode; only the FETCH-cycle IR/PC loads look at mem_ready_i.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'd0;
    alu_op_o        = 2'd0;
    pc_src_o        = 2'd0;
    ext_zero_o      = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'd1;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = 2'd3;
      end
      S_MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
      end
      S_MEMRD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      S_MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEMWR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'd2;
      end
      S_RWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = 2'd1;
        pc_write_cond_o = 1'b1;
        pc_src_o        = 2'd1;
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'd2;
      end
      S_IEXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        alu_op_o    = w_imm_alu_op;
        ext_zero_o  = w_imm_ext_zero;
      end
      S_IWB: begin
        reg_write_o = 1'b1;
        alu_op_o    = w_imm_alu_op;
        ext_zero_o  = w_imm_ext_zero;
      end
      default: ;
    endcase
  end

  assign illegal_o = r_illegal;
  assign state_o   = r_state;

`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  // An instruction retires when FETCH is re-entered from inside an
  // instruction; the first fetch after IDLE and FETCH wait cycles don't count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cycle_cnt <= 32'd0;
      r_instr_cnt <= 32'd0;
    end else begin
      if (r_state != S_IDLE && r_state != S_HALT) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
      if (w_next == S_FETCH && r_state != S_IDLE && r_state != S_FETCH) begin
        r_instr_cnt <= r_instr_cnt + 32'd1;
      end
    end
  end

  assign cycle_cnt_o = r_cycle_cnt;
  assign instr_cnt_o = r_instr_cnt;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm -- self-checking bench for mc_ctrl_fsm.
//
// A reference model expands each instruction (opcode plus memory wait counts)
// into the expected per-cycle trace of state, control outputs and sticky
// illegal flag, straight from the per-state output table. The bench replays
// the trace, driving mem_ready_i from it, and compares every cycle.
// Define MC_CTRL_PERF_CNT_EN to also exercise the performance counters.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iod;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       m2r;
    logic       rd;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic [1:0] psrc;
    logic       ez;
  } outs_t;

  typedef struct {
    int         st;
    bit         rdy;
    outs_t      o;
    bit         ill;
    logic [5:0] op;
  } item_t;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3,
                 S_MEMRD = 4, S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7,
                 S_RWB = 8, S_BRANCH = 9, S_JUMP = 10, S_IEXEC = 11,
                 S_IWB = 12, S_HALT = 13;

  logic       clk_i;
  logic       rst_i;
  logic [5:0] op_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o;
  logic       ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, alu_op_o, pc_src_o;
  logic       ext_zero_o, illegal_o;
  logic [3:0] state_o;
`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_o, instr_cnt_o;
`endif

  mc_ctrl_fsm dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .op_i            (op_i),
    .zero_i          (zero_i),
    .mem_ready_i     (mem_ready_i),
    .pc_write_o      (pc_write_o),
    .pc_write_cond_o (pc_write_cond_o),
    .i_or_d_o        (i_or_d_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .ir_write_o      (ir_write_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .reg_dst_o       (reg_dst_o),
    .reg_write_o     (reg_write_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_op_o        (alu_op_o),
    .pc_src_o        (pc_src_o),
    .ext_zero_o      (ext_zero_o),
    .illegal_o       (illegal_o),
    .state_o         (state_o)
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    .cycle_cnt_o     (cycle_cnt_o),
    .instr_cnt_o     (instr_cnt_o)
`endif
  );

  outs_t obs;
  assign obs = {pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
                ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
                alu_src_b_o, alu_op_o, pc_src_o, ext_zero_o};

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int    n_cmp = 0;
  int    n_bad = 0;
  string cur_test = "none";
  bit    m_ill = 1'b0;
  item_t q[$];

  // ---------------------------------------------------------------- model --
  task automatic push(input int st, input bit rdy, input outs_t o,
                      input logic [5:0] op);
    item_t it;
    it.st = st; it.rdy = rdy; it.o = o; it.ill = m_ill; it.op = op;
    q.push_back(it);
  endtask

  // Expected trace of one instruction: fw FETCH wait cycles, mw wait cycles
  // in the memory-access state.
  task automatic add_instr(input logic [5:0] op, input int fw, input int mw);
    outs_t o;
    for (int i = 0; i < fw; i++) begin
      o = '0; o.mr = 1; o.asb = 2'd1;
      push(S_FETCH, 1'b0, o, op);
    end
    o = '0; o.mr = 1; o.asb = 2'd1; o.irw = 1; o.pcw = 1;
    push(S_FETCH, 1'b1, o, op);
    o = '0; o.asb = 2'd3;
    push(S_DECODE, 1'($urandom), o, op);
    case (op)
      6'h00: begin
        o = '0; o.asa = 1; o.aop = 2'd2;       push(S_EXEC, 1'($urandom), o, op);
        o = '0; o.rw = 1; o.rd = 1;            push(S_RWB, 1'($urandom), o, op);
      end
      6'h23, 6'h2B: begin
        o = '0; o.asa = 1; o.asb = 2'd2;       push(S_MEMADR, 1'($urandom), o, op);
        if (op == 6'h23) begin
          o = '0; o.mr = 1; o.iod = 1;
          for (int i = 0; i < mw; i++) push(S_MEMRD, 1'b0, o, op);
          push(S_MEMRD, 1'b1, o, op);
          o = '0; o.rw = 1; o.m2r = 1;         push(S_MEMWB, 1'($urandom), o, op);
        end else begin
          o = '0; o.mw = 1; o.iod = 1;
          for (int i = 0; i < mw; i++) push(S_MEMWR, 1'b0, o, op);
          push(S_MEMWR, 1'b1, o, op);
        end
      end
      6'h04: begin
        o = '0; o.asa = 1; o.aop = 2'd1; o.pcwc = 1; o.psrc = 2'd1;
        push(S_BRANCH, 1'($urandom), o, op);
      end
      6'h02: begin
        o = '0; o.pcw = 1; o.psrc = 2'd2;      push(S_JUMP, 1'($urandom), o, op);
      end
      6'h08, 6'h0A, 6'h0D: begin
        logic [1:0] aop;
        aop = (op == 6'h08) ? 2'd0 : (op == 6'h0A) ? 2'd3 : 2'd2;
        o = '0; o.asa = 1; o.asb = 2'd2; o.aop = aop; o.ez = (op == 6'h0D);
        push(S_IEXEC, 1'($urandom), o, op);
        o = '0; o.rw = 1; o.aop = aop; o.ez = (op == 6'h0D);
        push(S_IWB, 1'($urandom), o, op);
      end
      default: begin
        m_ill = 1'b1;
        for (int i = 0; i < 3; i++) push(S_HALT, 1'($urandom), '0, op);
      end
    endcase
  endtask

  // Replays up to max_n expected cycles; entered and left at posedge+1.
  task automatic run_queue(input int max_n);
    item_t it;
    int n = 0;
    while (q.size() > 0 && n < max_n) begin
      it = q.pop_front();
      op_i = it.op; mem_ready_i = it.rdy; zero_i = 1'($urandom);
      @(negedge clk_i);
      n_cmp++;
      if (state_o !== it.st[3:0]) begin
        n_bad++;
        $display("FAIL %s state: got %0d want %0d", cur_test, state_o, it.st);
      end
      n_cmp++;
      if (obs !== it.o) begin
        n_bad++;
        $display("FAIL %s outputs in state %0d: got %h want %h", cur_test,
                 it.st, obs, it.o);
      end
      n_cmp++;
      if (illegal_o !== it.ill) begin
        n_bad++;
        $display("FAIL %s illegal_o in state %0d: got %b want %b", cur_test,
                 it.st, illegal_o, it.ill);
      end
      @(posedge clk_i); #1;
      n++;
    end
    q.delete();
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if (state_o !== 4'd0 || obs !== '0 || illegal_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s/%s: state=%0d outs=%h ill=%b want 0/0/0", cur_test, tag,
               state_o, obs, illegal_o);
    end
  endtask

  // Asserts reset (any time), checks at once and one edge later, releases
  // at posedge+1 and queues the expected IDLE cycle.
  task automatic do_reset();
    rst_i = 1'b0;
    mem_ready_i = 1'($urandom);
    #1 check_zero("async");
    @(posedge clk_i); #1;
    check_zero("held");
    rst_i = 1'b1;
    m_ill = 1'b0;
    q.delete();
    push(S_IDLE, 1'($urandom), '0, 6'h00);
  endtask

  // ---------------------------------------------------------------- tests --
  task automatic test_reset();
    cur_test = "reset";
    do_reset();
    run_queue(1);
  endtask

  task automatic test_rtype();
    cur_test = "rtype";
    do_reset();
    add_instr(6'h00, 0, 0);
    add_instr(6'h00, 0, 0);
    run_queue(1000);
  endtask

  task automatic test_lw_wait();
    cur_test = "lw_wait";
    add_instr(6'h23, 0, 3);
    add_instr(6'h2B, 0, 2);
    run_queue(1000);
  endtask

  task automatic test_branch_imm();
    cur_test = "branch_imm";
    add_instr(6'h04, 0, 0);
    add_instr(6'h0D, 0, 0);
    add_instr(6'h08, 0, 0);
    add_instr(6'h0A, 0, 0);
    add_instr(6'h02, 0, 0);
    run_queue(1000);
  endtask

  task automatic test_fetch_wait();
    cur_test = "fetch_wait";
    add_instr(6'h00, 2, 0);
    run_queue(1000);
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0A, 6'h0D};
    cur_test = "random";
    for (int i = 0; i < 60; i++) begin
      add_instr(ops[$urandom_range(7)], $urandom_range(2), $urandom_range(3));
    end
    run_queue(10000);
  endtask

  task automatic test_reset_mid();
    cur_test = "reset_mid";
    add_instr(6'h23, 0, 3);
    run_queue(5);          // abandon inside MEMRD
    do_reset();
    add_instr(6'h00, 0, 0);
    run_queue(1000);
  endtask

  task automatic test_halt();
    cur_test = "halt";
    add_instr(6'h3F, 0, 0);
    run_queue(1000);
    #2 do_reset();          // mid-cycle, away from any clock edge
    add_instr(6'h08, 1, 0);
    run_queue(1000);
  endtask

`ifdef MC_CTRL_PERF_CNT_EN
  task automatic test_perf();
    cur_test = "perf";
    do_reset();
    n_cmp++;
    if (cycle_cnt_o !== 32'd0 || instr_cnt_o !== 32'd0) begin
      n_bad++;
      $display("FAIL perf reset: cycles=%0d instrs=%0d want 0/0",
               cycle_cnt_o, instr_cnt_o);
    end
    for (int i = 0; i < 3; i++) add_instr(6'h00, 0, 0);
    run_queue(1000);
    n_cmp++;
    if (state_o !== 4'd1 || instr_cnt_o !== 32'd3 || cycle_cnt_o !== 32'd12) begin
      n_bad++;
      $display("FAIL perf count: state=%0d instrs=%0d cycles=%0d want 1/3/12",
               state_o, instr_cnt_o, cycle_cnt_o);
    end
  endtask
`endif

  initial begin
    rst_i = 1'b0; op_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch_imm();
    test_fetch_wait();
    test_random();
    test_reset_mid();
    test_halt();
`ifdef MC_CTRL_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS control unit: sequences the shared datapath (PC, instruction/data memory port, register file, Sign_Extend, ALU) through fetch/decode/execute/memory/writeback states.
- Replaces the single-cycle combinational decoder.
- Waits on a memory ready handshake.
- Drives all datapath mux selects and write enables.
- Includes the sign/zero extend select for the immediate path.

Parameters:
OP_W, 6, opcode field width.
ST_W, 4, state register width.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  reset, asynchronous, active-low.
op_i  in  OP_W  instr[31:26] from IR.
zero_i  in  1  ALU zero flag.
mem_ready_i  in  1  memory completes the current read/write this cycle.
pc_write_o  out  1  unconditional PC load.
pc_write_cond_o  out  1  PC load if zero_i (beq).
i_or_d_o  out  1  memory address select: 0=PC, 1=ALUOut.
mem_read_o  out  1  memory read request.
mem_write_o  out  1  memory write request.
ir_write_o  out  1  IR load.
mem_to_reg_o  out  1  writeback source: 1=MDR.
reg_dst_o  out  1  destination register: 1=rd, 0=rt.
reg_write_o  out  1  register file write.
alu_src_a_o  out  1  ALU A: 0=PC, 1=rs.
alu_src_b_o  out  2  ALU B: 0=rt, 1=const 4, 2=ext imm, 3=ext imm<<2.
alu_op_o  out  2  0=add, 1=sub, 2=funct, 3=slt.
pc_src_o  out  2  0=ALU, 1=ALUOut, 2=jump target.
ext_zero_o  out  1  1=zero-extend immediate, 0=sign-extend.
illegal_o  out  1  sticky: unknown opcode seen.
state_o  out  ST_W  current state, for debug.

Behaviour:
- Async reset (rst_i=0): state=IDLE (0), illegal_o=0, all outputs 0. Outputs stay 0 while reset is held, including reset mid-instruction; the partial instruction is abandoned with no write.
- IDLE -> FETCH unconditionally on the first clock after reset release.
- Outputs are a Moore decode of state, except pc_write_o and ir_write_o, which are additionally qualified by mem_ready_i in FETCH.
- Encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, IEXEC=11, IWB=12, HALT=13.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0.
  - Stay in FETCH while mem_ready_i=0, with ir_write=0 and pc_write=0.
  - On mem_ready_i=1: ir_write=1 and pc_write=1 for exactly that cycle; next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target). Next state by opcode:
  - 0x00 -> EXEC
  - 0x23 (lw) or 0x2B (sw) -> MEMADR
  - 0x04 (beq) -> BRANCH
  - 0x02 (j) -> JUMP
  - 0x08 (addi), 0x0A (slti) or 0x0D (ori) -> IEXEC
  - any other -> HALT; illegal_o is set.
- MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0, ext_zero=0. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1. Hold until mem_ready_i, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- MEMWR: mem_write=1, i_or_d=1. Hold until mem_ready_i, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=0, alu_op=2. Next RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_src=1. Next FETCH.
- JUMP: pc_write=1, pc_src=2. Next FETCH.
- IEXEC: alu_src_a=1, alu_src_b=2.
  - alu_op=0 for addi, 3 for slti, 2 for ori.
  - ext_zero=1 only for ori.
  - Next IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0. ext_zero and alu_op are held as in IEXEC. Next FETCH.
- HALT: all outputs 0, absorbing; exit only via reset.
- Per-instruction latency with zero memory wait:
  - R-type 4 cycles; addi/slti/ori 4; lw 5; sw 4; beq 3; j 3.
  - Each memory wait cycle adds 1.
- mem_read_o and mem_write_o are never both 1. reg_write_o is never 1 in a cycle with mem_write_o=1.
- The opcode is sampled in DECODE and again in IEXEC/IWB from the IR; the IR must stay stable, guaranteed because ir_write is asserted only in FETCH.

Optional Feature:
- Macro: MC_CTRL_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt_o[31:0] and instr_cnt_o[31:0].
  - cycle_cnt_o increments every cycle when state is not IDLE or HALT.
  - instr_cnt_o increments on every transition into FETCH from a non-IDLE state (instruction retired).
  - Both reset to 0 asynchronously and wrap 0xFFFFFFFF -> 0.
- Undefined: the ports are absent and no counter logic exists. FSM behaviour is identical either way.

Test Plan:
- Reset released, op_i=0x00, mem_ready_i=1 throughout -> state sequence 0,1,2,7,8,1; reg_write_o=1 and reg_dst_o=1 only in state 8.
- lw (0x23) with mem_ready_i low for 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_read_o=1 and i_or_d_o=1; MEMWB follows; total 8 cycles FETCH-to-FETCH.
- beq, zero_i=1 -> pc_write_cond_o=1 and pc_src_o=1 in BRANCH, back in FETCH after 3 cycles; ori (0x0D) -> ext_zero_o=1 in IEXEC and IWB, while addi (0x08) gives 0.
- FETCH with mem_ready_i=0 for 2 cycles, then 1 -> ir_write_o and pc_write_o pulse exactly once, in the third FETCH cycle.
- op_i=0x3F -> HALT, illegal_o=1, all outputs 0; rst_i pulsed low mid-HALT -> IDLE with illegal_o=0 immediately (asynchronously).
- With MC_CTRL_PERF_CNT_EN: run 3 R-type instructions at zero wait -> instr_cnt_o=3, cycle_cnt_o=12 at the fourth FETCH entry.
